// File: rtl/board_display_scanner.sv
// Scans a snapshotted nine-cell board image onto a nine-digit common-anode 7-segment bank.
// Latency: outputs registered one cycle after the digit index changes; snapshot taken once per frame.
// Backpressure: none; free-running scan, inputs sampled only at frame-boundary snapshot loads.
module board_display_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic [62:0] convert,
    input  logic [3:0]  I,
    input  logic        P1Won,
    input  logic        P2Won,
    output logic [8:0]  An,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic        FrameStart
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0] rc;
    logic [3:0]    d;
    logic [BW-1:0] bc;
    logic          phase;
    logic [62:0]   snap_conv;
    logic [3:0]    snap_I;
    logic          snap_win;
    logic          load_pending;

    logic          rc_tc;
    logic          bc_tc;
    logic          d_wrap;
    logic          load;
    logic [3:0]    d_safe;
    logic [6:0]    field;
    logic [8:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    assign rc_tc  = (rc == RW'(REFRESH_DIV - 1));
    assign bc_tc  = (bc == BW'(BLINK_DIV - 1));
    assign d_wrap = rc_tc && (d == 4'd8);
    // The very first cycle after reset loads a snapshot without advancing the scan,
    // so digit 0 gets its full dwell time from fresh data.
    assign load   = load_pending || d_wrap;
    assign d_safe = (d > 4'd8) ? 4'd0 : d;

    // Refresh counter and digit index; frozen during the initial snapshot load.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            rc <= '0;
            d  <= 4'd0;
        end else if (!load_pending) begin
            if (rc_tc) begin
                rc <= '0;
                d  <= (d >= 4'd8) ? 4'd0 : d + 4'd1;
            end else begin
                rc <= rc + RW'(1);
            end
        end
    end

    // Blink counter runs live from the first active cycle; it is never snapshotted.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            bc    <= '0;
            phase <= 1'b1;
        end else if (bc_tc) begin
            bc    <= '0;
            phase <= ~phase;
        end else begin
            bc    <= bc + BW'(1);
        end
    end

    // Board image snapshot, taken once per frame so a move never tears the display.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            snap_conv    <= '0;
            snap_I       <= 4'd0;
            snap_win     <= 1'b0;
            load_pending <= 1'b1;
            FrameStart   <= 1'b0;
        end else begin
            load_pending <= 1'b0;
            FrameStart   <= load;
            if (load) begin
                snap_conv <= convert;
                snap_I    <= I;
                snap_win  <= P1Won | P2Won;
            end
        end
    end

    // Select the current digit's pattern and apply cursor/win blinking.
    always_comb begin
        field   = snap_conv[6:0];
        for (int k = 0; k < 9; k++) begin
            if (d_safe == 4'(k)) field = snap_conv[7*k +: 7];
        end
        an_nxt  = ~(9'd1 << d_safe);
        seg_nxt = field;
        dp_nxt  = 1'b1;
        if (snap_win) begin
            if (!phase) begin
                an_nxt  = 9'h1FF;
                seg_nxt = 7'h7F;
            end
        end else if (snap_I == d_safe) begin
            // snap_I of 9..15 can never equal d_safe, so no cursor is shown then.
            if (phase) dp_nxt  = 1'b0;
            else       seg_nxt = 7'h7F;
        end
    end

    // Registered drive of the display bank; blank until the first snapshot is in place.
    always_ff @(posedge Clk) begin
        if (!reset_n || load_pending) begin
            An  <= 9'h1FF;
            Seg <= 7'h7F;
            Dp  <= 1'b1;
        end else begin
            An  <= an_nxt;
            Seg <= seg_nxt;
            Dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_board_display_scanner.sv
// Directed stimulus for board_display_scanner with REFRESH_DIV=4, BLINK_DIV=8.
// Snapshots are queued at each expected load edge and popped when that frame starts displaying.
// Outputs are sampled 1 time unit after each rising edge.
module tb_board_display_scanner;

    localparam int RD = 4;
    localparam int BD = 8;
    localparam int FRAME = 9 * RD;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic [62:0] convert;
    logic [3:0]  I;
    logic        P1Won;
    logic        P2Won;
    logic [8:0]  An;
    logic [6:0]  Seg;
    logic        Dp;
    logic        FrameStart;

    board_display_scanner #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .Clk(Clk), .reset_n(reset_n), .convert(convert), .I(I),
        .P1Won(P1Won), .P2Won(P2Won), .An(An), .Seg(Seg), .Dp(Dp),
        .FrameStart(FrameStart)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [62:0] c;
        logic [3:0]  i;
        logic        w;
    } snap_t;

    snap_t sbq[$];
    snap_t cur;
    int    n;
    int    vectors;
    int    errors;
    int    fs_count;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed %h expected %h", tag, n, got, exp);
        end
    endtask

    // One clock: update the reference, then compare all outputs.
    task automatic tick();
        logic       rst_at_edge;
        logic [8:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fs;
        logic [6:0] f;
        logic       ph;
        int         dd;
        snap_t      s;
        rst_at_edge = !reset_n;
        s.c = convert;
        s.i = I;
        s.w = P1Won | P2Won;
        @(posedge Clk);
        e_an = 9'h1FF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        if (rst_at_edge) begin
            n = -1;
            sbq.delete();
        end else begin
            n++;
            if (n % FRAME == 0) begin
                sbq.push_back(s);
                e_fs = 1'b1;
            end
            if (n % FRAME == 1) begin
                if (sbq.size() > 0) cur = sbq.pop_front();
                else begin
                    errors++;
                    $error("FAIL scoreboard_empty n=%0d observed 0 expected 1", n);
                end
            end
            if (n >= 1) begin
                dd = ((n - 1) % FRAME) / RD;
                ph = ((n / BD) % 2) == 0;
                f  = cur.c[7*dd +: 7];
                e_an = ~(9'd1 << dd);
                e_seg = f;
                if (cur.w) begin
                    if (!ph) begin e_an = 9'h1FF; e_seg = 7'h7F; end
                end else if (int'(cur.i) == dd) begin
                    if (ph) e_dp = 1'b0;
                    else    e_seg = 7'h7F;
                end
            end
        end
        #1;
        if (FrameStart === 1'b1) fs_count++;
        check("An", An, e_an);
        check("Seg", {2'b0, Seg}, {2'b0, e_seg});
        check("Dp", {8'b0, Dp}, {8'b0, e_dp});
        check("FrameStart", {8'b0, FrameStart}, {8'b0, e_fs});
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) tick();
    endtask

    task automatic set_fields_seq();
        for (int k = 0; k < 9; k++) convert[7*k +: 7] = 7'(k + 1);
    endtask

    task automatic set_fields_all(input logic [6:0] v);
        for (int k = 0; k < 9; k++) convert[7*k +: 7] = v;
    endtask

    // Advance until the next cycle satisfies the given digit/phase; bounded.
    task automatic run_until(input int want_d, input int want_ph);
        int  g;
        bit  hit;
        hit = 0;
        for (g = 0; g < 200 && !hit; g++) begin
            tick();
            if (n >= 1 && (((n - 1) % FRAME) / RD) == want_d &&
                (want_ph < 0 || ((n / BD) % 2 == 0) == (want_ph == 1))) hit = 1;
        end
        vectors++;
        assert (hit) else begin
            errors++;
            $error("FAIL wait_timeout n=%0d observed 0 expected 1", n);
        end
    endtask

    initial begin
        vectors = 0; errors = 0; n = -1; fs_count = 0;
        cur = '0;
        reset_n = 1'b0; convert = '0; I = 4'd15; P1Won = 1'b0; P2Won = 1'b0;
        @(negedge Clk);

        // Reset hold, then release with field k = k+1 and no cursor.
        run(5);
        set_fields_seq();
        reset_n = 1'b1;
        tick();
        check("rel_fs_c0", {8'b0, FrameStart}, 9'h001);
        tick();
        check("rel_an_c1", An, 9'h1FE);
        check("rel_seg_c1", {2'b0, Seg}, 9'h001);

        // Scan order over two full frames; one FrameStart per frame.
        fs_count = 0;
        run(2 * FRAME);
        check("fs_per_72", 9'(fs_count), 9'd2);

        // Tear-free update: field 0 = 40 loaded, then changed to 7F while d = 4.
        convert[6:0] = 7'h40;
        run(FRAME);
        run_until(4, -1);
        convert[6:0] = 7'h7F;
        run(2 * FRAME);

        // Cursor on cell 0 over all-40 board, then cursor off.
        I = 4'd0;
        set_fields_all(7'h40);
        run(3 * FRAME);
        I = 4'd9;
        run(2 * FRAME);

        // Win flash.
        P2Won = 1'b1;
        run(3 * FRAME);
        P2Won = 1'b0;
        I = 4'd3;
        run(FRAME);

        // Reset asserted at d = 5 during phase 0, then release.
        run_until(5, 0);
        reset_n = 1'b0;
        tick();
        check("midrst_an", An, 9'h1FF);
        tick();
        reset_n = 1'b1;
        run(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/board_display_scanner.md
# board_display_scanner

Consumes the board image produced by the game core: the 63-bit `convert` word, the cursor index `I`, and the `P1Won`/`P2Won` flags. It time-multiplexes the nine 7-bit cell patterns onto a nine-digit common-anode 7-segment bank. The cursor cell blinks. On a win, the whole bank blinks. The board image is snapshotted once per scan frame so a mid-frame move never tears the display.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit is driven; must be ≥ 2.
- `BLINK_DIV`, default 12500000: clock cycles per blink half-period; must be ≥ 2.
- `Clk`  in  1  system clock.
- `reset_n`  in  1  one clock; reset is synchronous and active-low.
- `convert`  in  63  cell k pattern in bits [7k+6:7k], k = 0..8, active-low segments gfedcba; driven to `Seg` unmodified.
- `I`  in  4  cursor cell; values 9..15 mean no cursor.
- `P1Won`  in  1  player 1 has won.
- `P2Won`  in  1  player 2 has won.
- `An`  out  9  digit enables, active-low, one-hot-low while lit; `An[k]` drives cell k.
- `Seg`  out  7  segment pattern, active-low.
- `Dp`  out  1  decimal point, active-low; lit only on the cursor digit while visible.
- `FrameStart`  out  1  one-cycle pulse when a new snapshot is loaded.

## Operation
- **Refresh counter** `rc`:
  - counts 0..REFRESH_DIV-1 and wraps to 0;
  - terminal count advances digit index `d` through 0..8, then 8→0.
- **Snapshot registers** `snap_conv`, `snap_I`, `snap_win` (= `P1Won | P2Won`):
  - load on the first active cycle after reset;
  - load again at every 8→0 wrap of `d`;
  - hold otherwise;
  - `FrameStart` = 1 in the cycle the load occurs.
- **Blink counter** `bc`:
  - counts 0..BLINK_DIV-1; at terminal count, toggles `phase`;
  - `phase` = 1 means visible.
  - Runs continuously and is not snapshotted.
- **Output selection** for current `d`, registered:
  - `snap_win` = 1 and `phase` = 0 → `An` = 9'h1FF, `Seg` = 7'h7F, `Dp` = 1.
  - `snap_win` = 1 and `phase` = 1 → `An` = ~(1<<d), `Seg` = field d, `Dp` = 1. Cursor is ignored while won.
  - `snap_win` = 0, `d` == `snap_I`, `phase` = 0 → `An` = ~(1<<d), `Seg` = 7'h7F (cursor digit blanked), `Dp` = 1.
  - `snap_win` = 0, `d` == `snap_I`, `phase` = 1 → `An` = ~(1<<d), `Seg` = field d, `Dp` = 0.
  - Any other case → `An` = ~(1<<d), `Seg` = field d, `Dp` = 1.
- `snap_I` ≥ 9 never matches, so no digit blinks.
- **Field extraction:** `convert[7d+6:7d]`. `d` never exceeds 8; an out-of-range `d` is unreachable and treated as 0.

## Timing
- **Reset** (`reset_n` = 0 sampled at posedge), all registers go to:
  - `rc` = 0, `d` = 0, `bc` = 0, `phase` = 1, snapshots = 0, load-pending = 1;
  - `An` = 9'h1FF, `Seg` = 7'h7F, `Dp` = 1, `FrameStart` = 0.
- **Reset asserted mid-frame:** outputs reach their reset values on the next edge, with no partial digit.
- **Cycle numbering:** cycle 0 is the first edge with `reset_n` = 1.
  - Cycle 0: snapshot loads; `FrameStart` = 1.
  - Cycle 1: outputs show digit 0 from the new snapshot.
- **Output latency:** one cycle after `d` changes. Each digit is visible for exactly REFRESH_DIV cycles; one frame = 9×REFRESH_DIV cycles.
- **Frame-boundary load:** the edge where `d` goes 8→0 also loads the snapshot. `FrameStart` = 1 that cycle; digit 0 of the new frame is displayed the following cycle with fresh data.
- **Input changes between loads** have no effect on `An`/`Seg`/`Dp`. The exception is blink timing, which follows `phase` live.
- **`phase` toggles** every BLINK_DIV cycles; the first toggle is at cycle BLINK_DIV-1.
- **Simultaneous events:** a blink toggle and a digit advance in the same cycle both take effect; the output then reflects the new `d` and the new `phase`.

## Test plan
Bench parameters: `REFRESH_DIV` = 4, `BLINK_DIV` = 8.

- **Reset hold and release:** hold `reset_n` = 0 for 5 cycles → `An` = 1FF, `Seg` = 7F, `Dp` = 1, `FrameStart` = 0. Release with field k = k+1 → `FrameStart` = 1 at cycle 0; `An` = 1FE, `Seg` = 7'h01 at cycle 1.
- **Scan order:** `I` = 15, no win → `An` steps 1FE, 1FD, …, 0FF every 4 cycles, `Seg` = 01..09. After 36 cycles `An` = 1FE again; `FrameStart` pulses exactly once per 36 cycles.
- **Tear-free update:** change field 0 from 7'h40 to 7'h7F while `d` = 4 → digit 0 still shows 7'h40 until the next frame, then shows 7'h7F.
- **Cursor blink:** `I` = 0, all fields 7'h40. Digit 0 during `phase` = 1 → `Seg` = 40, `Dp` = 0. Digit 0 during `phase` = 0 → `Seg` = 7F, `Dp` = 1, `An` = 1FE. Other digits are unaffected. Setting `I` = 9 → no blanking.
- **Win flash:** `P2Won` = 1 before a frame load → next frame has `An` = 1FF while `phase` = 0, and normal scan with `Dp` = 1 while `phase` = 1.
- **Reset mid-frame:** drive `reset_n` = 0 at `d` = 5, `phase` = 0 → next edge gives `An` = 1FF; after release, scanning restarts at digit 0 with `phase` = 1.
